mem_cfg_regfile: RTL and testbench
==================================

Name: mem_cfg_regfile

Overview:
Parametrised memory-mapped configuration register file for the switch, the slave side of the mem_sel_en / mem_wr_rd_s / mem_ack protocol.
Narrow writes (WR_W) are steered into a lane of a wide register (RD_W); reads return the full register.
It adds configurable wait states, read-only registers and an error response for illegal accesses.
It sits between the memory-access port and the switch's per-port configuration logic.

Parameters:
WR_W, 8, write data width; RD_W must be an integer multiple of WR_W.
RD_W, 32, register and read data width.
ADDR_W, 8, address width; NUM_REGS <= 2**ADDR_W.
NUM_REGS, 16, number of implemented registers (indices 0..NUM_REGS-1).
WAIT_STATES, 0, extra cycles inserted before mem_ack; range 0..15.
RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only.
RESET_VAL, {RD_W{1'b0}}, reset value of every register.
(local) LANES = RD_W/WR_W; LANE_W = max(1, $clog2(LANES)).

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mem_wr_data  input  WR_W  write data
mem_addr  input  ADDR_W  register index
mem_lane  input  LANE_W  write lane; lane k covers bits [k*WR_W +: WR_W]; ignored on reads
mem_sel_en  input  1  request valid
mem_wr_rd_s  input  1  1 = write, 0 = read
mem_rd_data  output  RD_W  read data
mem_ack  output  1  one-cycle completion pulse
mem_err  output  1  error flag, valid only while mem_ack = 1
busy  output  1  high while a transaction is in flight (not IDLE)

Behaviour:
- Reset (async assert): all registers = RESET_VAL; mem_rd_data = 0, mem_ack = 0, mem_err = 0, busy = 0; FSM = IDLE; wait counter = 0. Deassertion is taken synchronously.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: at an edge with mem_sel_en = 1, capture addr, lane, wr_data and wr_rd_s. Go to WAIT if WAIT_STATES > 0 (counter = WAIT_STATES-1), else go to ACK.
  - WAIT: counter decrements each edge; at 0 go to ACK.
  - ACK: mem_ack = 1 for exactly this cycle, then return to IDLE.
- All outputs are registered. Request captured at edge N -> mem_ack high between edges N+1+WAIT_STATES and N+2+WAIT_STATES.
- Inputs are ignored while busy = 1; captured values are used for the whole transaction.
- mem_sel_en still high in IDLE after ACK starts a new transaction, so the minimum period is WAIT_STATES+2 cycles.
- Write (legal):
  - Only lane mem_lane of reg[addr] is updated; other lanes are unchanged.
  - Commit occurs on the edge entering ACK.
  - mem_rd_data is unchanged.
- Read (legal): mem_rd_data = reg[addr], loaded on the edge entering ACK and held until the next read ack.
- Illegal access → mem_err = 1 together with mem_ack; no register is modified. Cases:
  - addr >= NUM_REGS: a read loads mem_rd_data = 0.
  - Write to a register with RO_MASK bit = 1.
  - mem_lane >= LANES, when LANES is not a power of 2.
- A read of an RO register is legal.
- Reset mid-transaction: the transaction is aborted, no write is committed, and no ack is issued.
- mem_err = 0 whenever mem_ack = 0.
- Register contents reflect a write from the cycle after its ack. A read issued immediately after a write to the same address returns the new value.

Test Plan:
- Reset, then read addr 0..15 -> each acks with mem_rd_data = 0x00000000, mem_err = 0; busy = 1 for exactly 2 cycles per access (WAIT_STATES = 0).
- Write 0xAB lane 2 to addr 3, then read addr 3 -> mem_rd_data = 0x00AB0000. Then write 0x5C lane 0 -> read returns 0x00AB005C.
- WAIT_STATES = 3: write captured at edge N -> mem_ack high only between edges N+4 and N+5; mem_addr/mem_wr_data toggled during WAIT -> written value = captured value.
- RO_MASK bit 5 = 1, RESET_VAL = 0x12345678: write 0xFF lane 1 to addr 5 -> mem_ack = 1, mem_err = 1; read addr 5 -> 0x12345678, mem_err = 0.
- Read addr 20 (NUM_REGS = 16) -> mem_err = 1, mem_rd_data = 0. Write addr 200 -> mem_err = 1, and a sweep shows registers 0..15 unchanged.
- Assert reset during WAIT of a write 0x77 to addr 1 -> no ack; busy = 0 immediately; read addr 1 -> RESET_VAL. mem_sel_en held high for 10 cycles (WAIT_STATES = 0) -> exactly 5 acks.

Source files
------------

// File: rtl/mem_cfg_regfile.sv
// mem_cfg_regfile: memory-mapped configuration register file.
// Narrow writes land in one lane of a wide register and reads return the
// full register. Optional wait states are inserted before the ack. Accesses to
// an unimplemented index, writes to a read-only register and writes to a
// nonexistent lane complete with an error and leave every register untouched.
module mem_cfg_regfile #(
  parameter int WR_W        = 8,
  parameter int RD_W        = 32,
  parameter int ADDR_W      = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}},
  parameter logic [RD_W-1:0]     RESET_VAL = {RD_W{1'b0}},
  localparam int LANES  = RD_W / WR_W,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WR_W-1:0]   mem_wr_data,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LANE_W-1:0] mem_lane,
  input  logic              mem_sel_en,
  input  logic              mem_wr_rd_s,
  output logic [RD_W-1:0]   mem_rd_data,
  output logic              mem_ack,
  output logic              mem_err,
  output logic              busy
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Bounds widened by one bit so they stay representable when they equal 2**W.
  localparam logic [ADDR_W:0] NUM_REGS_C = NUM_REGS[ADDR_W:0];
  localparam logic [LANE_W:0] LANES_C    = LANES[LANE_W:0];
  localparam logic [3:0]      WAIT_M1    = WAIT_STATES[3:0] - 4'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;

  // Request captured at the start of a transaction; held until it completes.
  logic [ADDR_W-1:0]   r_addr;
  logic [LANE_W-1:0]   r_lane;
  logic [WR_W-1:0]     r_wdata;
  logic                r_wr;

  logic [RD_W-1:0]     r_regs [NUM_REGS];
  logic [RD_W-1:0]     r_rd_data;
  logic                r_ack;
  logic                r_err;
  logic                r_busy;

  logic [IDX_W-1:0]    w_idx;
  logic                w_addr_ok;
  logic                w_lane_ok;
  logic                w_ro;
  logic                w_illegal;
  logic                w_start;
  logic [RD_W-1:0]     w_merged;

  assign w_idx     = r_addr[IDX_W-1:0];
  assign w_addr_ok = ({1'b0, r_addr} < NUM_REGS_C);
  assign w_lane_ok = ({1'b0, r_lane} < LANES_C);
  assign w_start   = (r_state == S_IDLE) && mem_sel_en;

  // Classify the captured request; reads of read-only registers are legal.
  always_comb begin
    w_ro      = 1'b0;
    w_illegal = 1'b0;
    if (w_addr_ok) begin
      w_ro = RO_MASK[w_idx];
    end else begin
      w_ro = 1'b0;
    end
    if (r_wr) begin
      w_illegal = !w_addr_ok || w_ro || !w_lane_ok;
    end else begin
      w_illegal = !w_addr_ok;
    end
  end

  // Merge the captured write data into the selected lane of the target register.
  always_comb begin
    w_merged = {RD_W{1'b0}};
    if (w_addr_ok) begin
      w_merged = r_regs[w_idx];
    end else begin
      w_merged = {RD_W{1'b0}};
    end
    for (int k = 0; k < LANES; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_merged[k*WR_W +: WR_W] = r_wdata;
      end else begin
        w_merged[k*WR_W +: WR_W] = w_merged[k*WR_W +: WR_W];
      end
    end
  end

  // Next-state and wait-counter logic of the transaction FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mem_sel_en) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WAIT_M1;
          end else begin
            w_state_nxt = S_ACK;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // FSM state and wait-counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request when a transaction starts; inputs are ignored otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_lane  <= {LANE_W{1'b0}};
      r_wdata <= {WR_W{1'b0}};
      r_wr    <= 1'b0;
    end else if (w_start) begin
      r_addr  <= mem_addr;
      r_lane  <= mem_lane;
      r_wdata <= mem_wr_data;
      r_wr    <= mem_wr_rd_s;
    end
  end

  // Register array: a legal write commits on the edge that raises the ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if ((r_state == S_ACK) && r_wr && !w_illegal) begin
      r_regs[w_idx] <= w_merged;
    end
  end

  // Registered response: ack/err pulse, read data and busy flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data <= {RD_W{1'b0}};
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ack  <= (r_state == S_ACK);
      r_err  <= (r_state == S_ACK) && w_illegal;
      // Busy covers the whole request up to and including the ack cycle.
      r_busy <= (w_state_nxt != S_IDLE) || (r_state == S_ACK);
      if ((r_state == S_ACK) && !r_wr) begin
        if (w_addr_ok) begin
          r_rd_data <= r_regs[w_idx];
        end else begin
          r_rd_data <= {RD_W{1'b0}};
        end
      end
    end
  end

  assign mem_rd_data = r_rd_data;
  assign mem_ack     = r_ack;
  assign mem_err     = r_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mem_cfg_regfile.sv
// Directed testbench for mem_cfg_regfile. Instance 0 uses the default
// parameters; instance 1 has three wait states, register 5 read-only and a
// non-zero reset value.
module tb_mem_cfg_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel   [2];
  logic        wrs   [2];
  logic [7:0]  addr  [2];
  logic [7:0]  wdata [2];
  logic [1:0]  lane  [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_cfg_regfile u_dut0 (
    .clock(clock), .reset(reset), .mem_wr_data(wdata[0]), .mem_addr(addr[0]),
    .mem_lane(lane[0]), .mem_sel_en(sel[0]), .mem_wr_rd_s(wrs[0]),
    .mem_rd_data(rdata[0]), .mem_ack(ack[0]), .mem_err(err[0]), .busy(busy[0])
  );

  mem_cfg_regfile #(
    .WAIT_STATES(3), .RO_MASK(16'h0020), .RESET_VAL(32'h12345678)
  ) u_dut1 (
    .clock(clock), .reset(reset), .mem_wr_data(wdata[1]), .mem_addr(addr[1]),
    .mem_lane(lane[1]), .mem_sel_en(sel[1]), .mem_wr_rd_s(wrs[1]),
    .mem_rd_data(rdata[1]), .mem_ack(ack[1]), .mem_err(err[1]), .busy(busy[1])
  );

  // One transaction: returns read data, error flag and the number of falling
  // edges from the capture edge to the first one seeing ack (-1 on timeout).
  task automatic txn(input int d, input logic wr, input logic [7:0] a,
                     input logic [1:0] ln, input logic [7:0] dat,
                     output logic [31:0] o_rd, output logic o_err, output int lat);
    @(negedge clock);
    sel[d] = 1'b1; wrs[d] = wr; addr[d] = a; lane[d] = ln; wdata[d] = dat;
    @(posedge clock);
    #1;
    sel[d] = 1'b0;
    lat = -1; o_rd = 32'h0; o_err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (ack[d]) begin
        lat = i; o_rd = rdata[d]; o_err = err[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({rdata[d], ack[d], err[d], busy[d]} !== 35'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got rd=%h ack=%b err=%b busy=%b required all 0",
                 d, rdata[d], ack[d], err[d], busy[d]);
      end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_read_sweep();
    logic [31:0] rd; logic e; int lat; int bcnt;
    for (int a = 0; a < 16; a++) begin
      txn(0, 1'b0, 8'(a), 2'd0, 8'h00, rd, e, lat);
      n_tests++;
      if (rd !== 32'h0 || e !== 1'b0 || lat !== 2) begin
        n_fail++;
        $display("FAIL sweep_read addr %0d: got rd=%h err=%b lat=%0d required 00000000/0/2",
                 a, rd, e, lat);
      end
    end
    // Busy must be high for exactly two cycles of a zero-wait access.
    @(negedge clock);
    n_tests++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle: got %b required 0", busy[0]);
    end
    sel[0] = 1'b1; wrs[0] = 1'b0; addr[0] = 8'd0;
    @(posedge clock);
    #1;
    sel[0] = 1'b0;
    bcnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (busy[0]) bcnt++;
    end
    n_tests++;
    if (bcnt !== 2) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d required 2", bcnt);
    end
  endtask

  task automatic test_lane_write();
    logic [31:0] rd; logic e; int lat;
    txn(0, 1'b1, 8'd3, 2'd2, 8'hAB, rd, e, lat);
    n_tests++;
    if (e !== 1'b0 || lat !== 2) begin
      n_fail++;
      $display("FAIL lane2_write: got err=%b lat=%0d required 0/2", e, lat);
    end
    txn(0, 1'b0, 8'd3, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'h00AB0000 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lane2_read: got %h err=%b required 00ab0000/0", rd, e);
    end
    txn(0, 1'b1, 8'd3, 2'd0, 8'h5C, rd, e, lat);
    txn(0, 1'b0, 8'd3, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'h00AB005C || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lane0_read: got %h err=%b required 00ab005c/0", rd, e);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic e; int lat; logic [31:0] exp;
    txn(0, 1'b0, 8'd20, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'h0 || e !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL read_oob: got rd=%h err=%b lat=%0d required 00000000/1/2", rd, e, lat);
    end
    txn(0, 1'b1, 8'd200, 2'd1, 8'hEE, rd, e, lat);
    n_tests++;
    if (e !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL write_oob: got err=%b lat=%0d required 1/2", e, lat);
    end
    for (int a = 0; a < 16; a++) begin
      exp = (a == 3) ? 32'h00AB005C : 32'h0;
      txn(0, 1'b0, 8'(a), 2'd0, 8'h00, rd, e, lat);
      n_tests++;
      if (rd !== exp || e !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_after_oob addr %0d: got %h err=%b required %h/0", a, rd, e, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks; int errs;
    acks = 0; errs = 0;
    @(negedge clock);
    sel[0] = 1'b1; wrs[0] = 1'b0; addr[0] = 8'd3;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (ack[0]) acks++;
      if (err[0]) errs++;
      if (i == 9) sel[0] = 1'b0;
    end
    n_tests++;
    if (acks !== 5 || errs !== 0) begin
      n_fail++;
      $display("FAIL back_to_back: got acks=%0d errs=%0d required 5/0", acks, errs);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic e; int lat; logic [5:0] seen;
    @(negedge clock);
    sel[1] = 1'b1; wrs[1] = 1'b1; addr[1] = 8'd7; lane[1] = 2'd1; wdata[1] = 8'h3C;
    @(posedge clock);
    #1;
    sel[1] = 1'b0;
    seen = 6'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      seen[k-1] = ack[1];
      // Disturb the request inputs while the transaction is in flight.
      addr[1] = 8'd9; wdata[1] = 8'hEE; lane[1] = 2'd3; wrs[1] = 1'b0;
    end
    n_tests++;
    if (seen !== 6'b010000) begin
      n_fail++;
      $display("FAIL wait_ack_timing: got %b required 010000", seen);
    end
    txn(1, 1'b0, 8'd7, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'h12343C78 || e !== 1'b0 || lat !== 5) begin
      n_fail++;
      $display("FAIL wait_captured: got rd=%h err=%b lat=%0d required 12343c78/0/5", rd, e, lat);
    end
    txn(1, 1'b0, 8'd9, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL wait_other_reg: got %h required 12345678", rd);
    end
  endtask

  task automatic test_read_only();
    logic [31:0] rd; logic e; int lat;
    txn(1, 1'b1, 8'd5, 2'd1, 8'hFF, rd, e, lat);
    n_tests++;
    if (e !== 1'b1 || lat !== 5) begin
      n_fail++;
      $display("FAIL ro_write: got err=%b lat=%0d required 1/5", e, lat);
    end
    txn(1, 1'b0, 8'd5, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'h12345678 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL ro_read: got %h err=%b required 12345678/0", rd, e);
    end
    txn(1, 1'b1, 8'd6, 2'd3, 8'hA5, rd, e, lat);
    txn(1, 1'b0, 8'd6, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'hA5345678 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_neighbour: got %h err=%b required a5345678/0", rd, e);
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] rd; logic e; int lat; int acks;
    @(negedge clock);
    sel[1] = 1'b1; wrs[1] = 1'b1; addr[1] = 8'd1; lane[1] = 2'd0; wdata[1] = 8'h77;
    @(posedge clock);
    #1;
    sel[1] = 1'b0;
    @(negedge clock);
    n_tests++;
    if (busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy_before: got %b required 1", busy[1]);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy[1] !== 1'b0 || ack[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_busy: got busy=%b ack=%b required 0/0", busy[1], ack[1]);
    end
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack[1]) acks++;
    end
    n_tests++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_noack: got %0d acks required 0", acks);
    end
    txn(1, 1'b0, 8'd1, 2'd0, 8'h00, rd, e, lat);
    n_tests++;
    if (rd !== 32'h12345678 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_read: got %h err=%b required 12345678/0", rd, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; wrs[d] = 1'b0; addr[d] = 8'h0; wdata[d] = 8'h0; lane[d] = 2'd0;
    end
    test_reset();
    test_read_sweep();
    test_lane_write();
    test_illegal();
    test_back_to_back();
    test_wait_states();
    test_read_only();
    test_reset_mid_txn();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
